// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two synchronous
// write ports, and a per-register pending scoreboard used by the hazard unit.
// Every read port bypasses same-cycle writebacks, so decode sees a result in
// the cycle it is written back.

// Per-read-port logic: zero-register forcing, write bypass and the busy flag.
module regfile_mp_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                   run_i,     // low while reset is asserted
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [1:0]             wr_vld_i,  // write ports already qualified
  input  logic [1:0][ADDR_W-1:0] wr_addr_i,
  input  logic [1:0][DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0]      row_i,     // stored value at addr_i
  input  logic                   pend_i,    // registered pending bit at addr_i
  output logic [DATA_W-1:0]      data_o,
  output logic                   busy_o
);
  logic is_zero;
  logic hit0, hit1;

  assign is_zero = (ZERO_REG != 0) && (addr_i == '0);
  assign hit1    = wr_vld_i[1] && (wr_addr_i[1] == addr_i);
  assign hit0    = wr_vld_i[0] && (wr_addr_i[0] == addr_i);

  // Read mux: port 1 beats port 0 to match the write collision rule.
  always_comb begin
    data_o = row_i;
    if (!run_i || is_zero) data_o = '0;
    else if (hit1)         data_o = wr_data_i[1];
    else if (hit0)         data_o = wr_data_i[0];
  end

  // A writeback landing this cycle resolves the hazard immediately.
  always_comb begin
    busy_o = run_i && !is_zero && pend_i && !(hit0 || hit1);
  end
endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,   // asynchronous, active low
  input  logic [1:0]               wr_en_i,
  input  logic [2*ADDR_W-1:0]      wr_addr_i,
  input  logic [2*DATA_W-1:0]      wr_data_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  input  logic [NRD*ADDR_W-1:0]    rd_addr_i,
  output logic [NRD*DATA_W-1:0]    rd_data_o,
  output logic [NRD-1:0]           rd_busy_o,
  output logic [(1<<ADDR_W)-1:0]   pend_vec_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [1:0][ADDR_W-1:0]      wa;
  logic [1:0][DATA_W-1:0]      wd;
  logic [1:0]                  wr_vld;
  logic [NRD-1:0][ADDR_W-1:0]  ra;
  logic [NRD-1:0][DATA_W-1:0]  rdat;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             pend_q, pend_d;
  logic [DEPTH-1:0]             set_vec, clr_vec;

  assign wa        = wr_addr_i;
  assign wd        = wr_data_i;
  assign ra        = rd_addr_i;
  assign rd_data_o = rdat;
  assign pend_vec_o = pend_q;

  // Qualify write ports: register 0 is read-only when ZERO_REG is set, and
  // nothing is treated as a write (or bypassed) while reset is held.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wr_vld[k] = reset_i && wr_en_i[k] && !((ZERO_REG != 0) && (wa[k] == '0));
    end
  end

  // Next array contents; port 1 applied last so it wins an address collision.
  always_comb begin
    mem_d = mem_q;
    if (wr_vld[0]) mem_d[wa[0]] = wd[0];
    if (wr_vld[1]) mem_d[wa[1]] = wd[1];
  end

  // Register array storage.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) mem_q <= '0;
    else          mem_q <= mem_d;
  end

  // Per-register scoreboard set (issue) and clear (writeback) terms.
  for (genvar i = 0; i < DEPTH; i++) begin : g_sb
    assign clr_vec[i] = (wr_vld[0] && (wa[0] == ADDR_W'(i))) ||
                        (wr_vld[1] && (wa[1] == ADDR_W'(i)));
    assign set_vec[i] = reset_i && iss_en_i && (iss_addr_i == ADDR_W'(i)) &&
                        !((ZERO_REG != 0) && (i == 0));
  end

  // Set dominates clear: a new producer issued in the writeback cycle keeps
  // the register pending.
  always_comb begin
    pend_d = (pend_q & ~clr_vec) | set_vec;
  end

  // Pending scoreboard state.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) pend_q <= '0;
    else          pend_q <= pend_d;
  end

  // One read lane per port; issue inputs never reach these outputs.
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .run_i     (reset_i),
      .addr_i    (ra[j]),
      .wr_vld_i  (wr_vld),
      .wr_addr_i (wa),
      .wr_data_i (wd),
      .row_i     (mem_q[ra[j]]),
      .pend_i    (pend_q[ra[j]]),
      .data_o    (rdat[j]),
      .busy_o    (rd_busy_o[j])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build, a ZERO_REG=0 build and a
// 4-port 64-bit build driven from the same stimulus.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [4:0]  wa0, wa1, iss_addr, ra0, ra1;
  logic [31:0] wd0, wd1;
  logic        iss_en;

  logic [63:0]  rd_data;
  logic [1:0]   rd_busy;
  logic [31:0]  pend_vec;
  logic [63:0]  rd_data_z;
  logic [1:0]   rd_busy_z;
  logic [31:0]  pend_vec_z;
  logic [255:0] rd_data_w;
  logic [3:0]   rd_busy_w;
  logic [31:0]  pend_vec_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Wide build sees each 32-bit word with its halves swapped in the upper half.
  function automatic logic [31:0] sw(input logic [31:0] x);
    return {x[15:0], x[31:16]};
  endfunction

  regfile_mp dut (
    .clk_i(clk), .reset_i(rst_n), .wr_en_i(wr_en), .wr_addr_i({wa1, wa0}),
    .wr_data_i({wd1, wd0}), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .rd_addr_i({ra1, ra0}), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .pend_vec_o(pend_vec));

  regfile_mp #(.ZERO_REG(0)) dut_z (
    .clk_i(clk), .reset_i(rst_n), .wr_en_i(wr_en), .wr_addr_i({wa1, wa0}),
    .wr_data_i({wd1, wd0}), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .rd_addr_i({ra1, ra0}), .rd_data_o(rd_data_z), .rd_busy_o(rd_busy_z),
    .pend_vec_o(pend_vec_z));

  regfile_mp #(.DATA_W(64), .NRD(4)) dut_w (
    .clk_i(clk), .reset_i(rst_n), .wr_en_i(wr_en), .wr_addr_i({wa1, wa0}),
    .wr_data_i({sw(wd1), wd1, sw(wd0), wd0}), .iss_en_i(iss_en),
    .iss_addr_i(iss_addr), .rd_addr_i({ra1, ra0, ra1, ra0}),
    .rd_data_o(rd_data_w), .rd_busy_o(rd_busy_w), .pend_vec_o(pend_vec_w));

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 2'b00; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  r0, r1;
    logic [31:0] e0, e1;   // expected rd data, default build
    logic [31:0] ez;       // expected port 1 data, ZERO_REG=0 build
    logic [1:0]  eb;       // expected rd_busy
    logic [31:0] ep;       // expected pend_vec (pre-edge)
  } vec_t;

  vec_t tbl[17];
  localparam logic [31:0] P9 = 32'h0000_0200;

  initial begin
    tbl[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 2'b00, 32'h0};
    tbl[1]  = '{2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h1234, 2'b00, 32'h0};
    tbl[2]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h1234, 2'b00, 32'h0};
    tbl[3]  = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22, 32'h22, 32'h22, 2'b00, 32'h0};
    tbl[4]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0};
    tbl[5]  = '{2'b01, 5'd8, 32'h33, 5'd0, 32'h0, 1'b0, 5'd0, 5'd8, 5'd7, 32'h33, 32'h22, 32'h22, 2'b00, 32'h0};
    tbl[6]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd8, 32'h0, 32'h33, 32'h33, 2'b00, 32'h0};
    tbl[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd8, 32'h0, 32'h33, 32'h33, 2'b01, P9};
    tbl[8]  = '{2'b10, 5'd0, 32'h0, 5'd9, 32'h55, 1'b0, 5'd0, 5'd9, 5'd9, 32'h55, 32'h55, 32'h55, 2'b00, P9};
    tbl[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 32'h55, 32'h0, 32'h1234, 2'b00, 32'h0};
    tbl[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 32'h55, 32'h0, 32'h1234, 2'b00, 32'h0};
    tbl[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 32'h55, 32'h0, 32'h1234, 2'b01, P9};
    tbl[12] = '{2'b01, 5'd9, 32'h66, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 32'h66, 32'h0, 32'h1234, 2'b00, P9};
    tbl[13] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd9, 5'd0, 32'h66, 32'h0, 32'h1234, 2'b01, P9};
    tbl[14] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h66, 32'h66, 2'b10, P9};
    tbl[15] = '{2'b10, 5'd0, 32'h0, 5'd10, 32'h77, 1'b0, 5'd0, 5'd10, 5'd9, 32'h77, 32'h66, 32'h66, 2'b10, P9};
    tbl[16] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd9, 32'h77, 32'h66, 32'h66, 2'b10, P9};

    // Reset held with writes and an issue active: nothing may be visible or captured.
    rst_n = 1'b0;
    wr_en = 2'b11; wa0 = 5'd5; wd0 = 32'hAAAA_0001; wa1 = 5'd6; wd1 = 32'hBBBB_0002;
    iss_en = 1'b1; iss_addr = 5'd9; ra0 = 5'd5; ra1 = 5'd6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rd_data", rd_data, 64'h0);
    chk("rst rd_busy", rd_busy, 2'b00);
    chk("rst pend", pend_vec, 32'h0);
    chk("rst wide rd_data", rd_data_w, 256'h0);
    idle();
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 32; a += 2) begin
      ra0 = 5'(a); ra1 = 5'(a + 1);
      #1;
      chk($sformatf("post-rst r%0d/r%0d", a, a + 1), rd_data, 64'h0);
      chk($sformatf("post-rst z r%0d/r%0d", a, a + 1), rd_data_z, 64'h0);
    end
    chk("post-rst pend", pend_vec, 32'h0);
    chk("post-rst wide pend", pend_vec_w, 32'h0);

    // Table-driven vectors: inputs applied after an edge, outputs sampled mid-cycle.
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      wr_en = tbl[i].we; wa0 = tbl[i].a0; wd0 = tbl[i].d0; wa1 = tbl[i].a1; wd1 = tbl[i].d1;
      iss_en = tbl[i].ie; iss_addr = tbl[i].ia; ra0 = tbl[i].r0; ra1 = tbl[i].r1;
      @(negedge clk);
      chk($sformatf("v%0d rd0", i), rd_data[31:0], tbl[i].e0);
      chk($sformatf("v%0d rd1", i), rd_data[63:32], tbl[i].e1);
      chk($sformatf("v%0d busy", i), rd_busy, tbl[i].eb);
      chk($sformatf("v%0d pend", i), pend_vec, tbl[i].ep);
      chk($sformatf("v%0d z rd1", i), rd_data_z[63:32], tbl[i].ez);
      chk($sformatf("v%0d w rd", i), rd_data_w,
          {sw(tbl[i].e1), tbl[i].e1, sw(tbl[i].e0), tbl[i].e0,
           sw(tbl[i].e1), tbl[i].e1, sw(tbl[i].e0), tbl[i].e0});
      chk($sformatf("v%0d w busy", i), rd_busy_w, {tbl[i].eb, tbl[i].eb});
      chk($sformatf("v%0d w pend", i), pend_vec_w, tbl[i].ep);
    end

    // Asynchronous reset between edges clears state without waiting for a clock.
    @(posedge clk); #1;
    idle();
    wr_en = 2'b01; wa0 = 5'd3; wd0 = 32'hA5; iss_en = 1'b1; iss_addr = 5'd4;
    @(posedge clk); #1;
    idle();
    ra0 = 5'd3; ra1 = 5'd4;
    #1;
    chk("mid r3 before rst", rd_data[31:0], 32'hA5);
    chk("mid busy before rst", rd_busy, 2'b10);
    chk("mid pend before rst", pend_vec, P9 | 32'h10);
    #1 rst_n = 1'b0;
    #1;
    chk("mid r3 in rst", rd_data, 64'h0);
    chk("mid busy in rst", rd_busy, 2'b00);
    chk("mid pend in rst", pend_vec, 32'h0);
    chk("mid wide pend in rst", pend_vec_w, 32'h0);
    chk("mid wide rd in rst", rd_data_w, 256'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid r3 after rst", rd_data, 64'h0);
    chk("mid pend after rst", pend_vec, 32'h0);
    chk("mid z r3 after rst", rd_data_z, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
